// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared types and helpers for the debounce scheduler slice.
//   - sched_state_t : scheduler FSM state (IDLE / TIMING)
//   - clog2_min1()  : ceil(log2(v)) clamped to at least 1, used to size
//                     the shared timer and the channel index
package debounce_pkg;

   typedef enum logic {IDLE, TIMING} sched_state_t;

   // Width helper: a 1-entry or 2-entry range still needs a 1-bit field.
   function automatic int clog2_min1(input int v);
      int r;
      r = $clog2(v);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if
//   Groups the pad-side and user-side signals of the debounce scheduler.
//   - noisy     : raw asynchronous pad levels           (slave -> master)
//   - debounced : committed clean levels                (master -> slave)
//   - changed   : one-cycle pulse on the committed bit  (master -> slave)
//   - busy      : shared timer currently granted        (master -> slave)
//   - active_ch : granted channel, holds last grant     (master -> slave)
//   - state     : scheduler FSM state, for observation  (master -> slave)
//   Handshake semantics: there is no valid/ready pair; all signals are
//   levels sampled on clk, except changed, which is a single-cycle pulse
//   with no backpressure (the consumer must sample it in that cycle).
interface debounce_scheduler_if
   import debounce_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int CH_W = clog2_min1(NUM_CH)
);
   logic [NUM_CH-1:0] noisy;
   logic [NUM_CH-1:0] debounced;
   logic [NUM_CH-1:0] changed;
   logic              busy;
   logic [CH_W-1:0]   active_ch;
   sched_state_t      state;

   // master: the scheduler itself
   modport master (
      input  noisy,
      output debounced, changed, busy, active_ch, state
   );

   // slave: pads drive noisy, user logic consumes the rest
   modport slave (
      output noisy,
      input  debounced, changed, busy, active_ch, state
   );
endinterface

// File: rtl/debounce_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Returns the first requesting channel
//   at or after ptr, wrapping modulo NUM_CH.
//   - req         : request vector
//   - ptr         : highest-priority channel index
//   - grant_valid : at least one request present
//   - grant       : selected channel index (0 when grant_valid is low)
module rr_arbiter
   import debounce_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int CH_W = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic              grant_valid,
   output logic [CH_W-1:0]   grant
);

   // Scan from the farthest offset down to offset 0 so the nearest
   // requester (lowest offset from ptr) is the last, and winning, write.
   always_comb begin
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant       = '0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[idx[CH_W-1:0]]) begin
            grant_valid = 1'b1;
            grant       = idx[CH_W-1:0];
         end
      end
   end

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Debounces NUM_CH noisy inputs with one shared timer. A round-robin
//   arbiter grants the timer to one mismatching channel at a time; the
//   channel's new level is committed only after it persists for
//   DEBOUNCE_CYCLES cycles.
//   - clk     : system clock, rising edge
//   - reset_n : asynchronous active-low reset
//   - bus     : debounce_scheduler_if.master (noisy in; debounced, changed,
//               busy, active_ch, state out)
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES),
   localparam int CH_W  = clog2_min1(NUM_CH)
) (
   input logic                  clk,
   input logic                  reset_n,
   debounce_scheduler_if.master bus
);

   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0] debounced_q;
   logic [NUM_CH-1:0] changed_q;
   logic [NUM_CH-1:0] req;
   logic              busy_q;
   logic [CH_W-1:0]   active_q;
   logic [CH_W-1:0]   ptr_q;
   logic [CH_W-1:0]   ptr_after;
   logic [CNT_W-1:0]  timer_q;
   sched_state_t      state_q;
   logic              grant_valid;
   logic [CH_W-1:0]   grant_idx;

   // A channel wants the timer whenever its synchronized level differs
   // from its committed level; no other pending state is kept.
   assign req = sync_q ^ debounced_q;

   // Pointer moves past the channel just serviced, whether it committed
   // or aborted, so every requester is reached within NUM_CH-1 windows.
   assign ptr_after = (active_q == CH_LAST) ? '0 : active_q + 1'b1;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req         (req),
      .ptr         (ptr_q),
      .grant_valid (grant_valid),
      .grant       (grant_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= '0;
         sync_q      <= '0;
         debounced_q <= '0;
         changed_q   <= '0;
         busy_q      <= 1'b0;
         active_q    <= '0;
         ptr_q       <= '0;
         timer_q     <= '0;
         state_q     <= IDLE;
      end else begin
         sync1_q   <= bus.noisy;
         sync_q    <= sync1_q;
         changed_q <= '0;
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  active_q <= grant_idx;
                  timer_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= TIMING;
               end
            end
            TIMING: begin
               if (sync_q[active_q] == debounced_q[active_q]) begin
                  // Bounced back to the committed level: drop the window.
                  busy_q  <= 1'b0;
                  ptr_q   <= ptr_after;
                  state_q <= IDLE;
               end else if (timer_q == TIMER_LAST) begin
                  debounced_q[active_q] <= sync_q[active_q];
                  changed_q[active_q]   <= 1'b1;
                  busy_q                <= 1'b0;
                  ptr_q                 <= ptr_after;
                  state_q               <= IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.debounced = debounced_q;
   assign bus.changed   = changed_q;
   assign bus.busy      = busy_q;
   assign bus.active_ch = active_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler
//   Directed bench for debounce_scheduler with NUM_CH=4, DEBOUNCE_CYCLES=8.
//   Time reference in each step: "e0" is the edge just before noisy is
//   changed; sync delay is 2 edges, so a grant lands on e3 and a commit on
//   e11 when the input holds steady.
module tb_debounce_scheduler;
   import debounce_pkg::*;

   localparam int NUM_CH = 4;
   localparam int DEB    = 8;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   debounce_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

   debounce_scheduler #(.NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Advance one edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Assert reset now, check outputs clear at once and stay clear for
   // ncyc edges, then release just after an edge with noisy = nval.
   task automatic apply_reset(input logic [3:0] nval, input int ncyc, input string tag);
      reset_n   = 1'b0;
      bus.noisy = nval;
      #1;
      chk({tag, "_imm_deb"},  32'(bus.debounced), 32'h0);
      chk({tag, "_imm_busy"}, 32'(bus.busy),      32'h0);
      chk({tag, "_imm_chg"},  32'(bus.changed),   32'h0);
      chk({tag, "_imm_act"},  32'(bus.active_ch), 32'h0);
      for (int i = 0; i < ncyc; i++) begin
         tick();
         chk({tag, "_hold_deb"},  32'(bus.debounced), 32'h0);
         chk({tag, "_hold_chg"},  32'(bus.changed),   32'h0);
         chk({tag, "_hold_busy"}, 32'(bus.busy),      32'h0);
         chk({tag, "_hold_act"},  32'(bus.active_ch), 32'h0);
      end
      reset_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset_n   = 1'b0;
      bus.noisy = '0;
      #2;

      // 1) reset with all inputs high; ch0 is served first after release
      apply_reset(4'b1111, 5, "rst");
      tick(); tick();
      chk("rst_e2_busy", 32'(bus.busy), 32'h0);
      tick();
      chk("rst_e3_busy", 32'(bus.busy), 32'h1);
      chk("rst_e3_act",  32'(bus.active_ch), 32'h0);
      chk("rst_e3_state", 32'(bus.state), 32'(TIMING));
      repeat (7) tick();
      chk("rst_e10_deb", 32'(bus.debounced), 32'h0);
      tick();
      chk("rst_e11_deb",  32'(bus.debounced), 32'h1);
      chk("rst_e11_chg",  32'(bus.changed),   32'h1);
      chk("rst_e11_busy", 32'(bus.busy),      32'h0);
      tick();
      chk("rst_e12_chg",  32'(bus.changed),   32'h0);
      chk("rst_e12_busy", 32'(bus.busy),      32'h1);
      chk("rst_e12_act",  32'(bus.active_ch), 32'h1);

      // 2) clean press on ch2
      apply_reset(4'b0000, 2, "rst2");
      tick(); tick();
      bus.noisy = 4'b0100;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 2) chk("press_e2_busy", 32'(bus.busy), 32'h0);
         if (i >= 3 && i <= 10) begin
            chk("press_win_busy", 32'(bus.busy),      32'h1);
            chk("press_win_act",  32'(bus.active_ch), 32'h2);
            chk("press_win_chg",  32'(bus.changed),   32'h0);
            chk("press_win_deb",  32'(bus.debounced), 32'h0);
         end
         if (i == 11) begin
            chk("press_e11_deb",  32'(bus.debounced), 32'h4);
            chk("press_e11_chg",  32'(bus.changed),   32'h4);
            chk("press_e11_busy", 32'(bus.busy),      32'h0);
         end
         if (i == 12) begin
            chk("press_e12_chg",  32'(bus.changed),   32'h0);
            chk("press_e12_busy", 32'(bus.busy),      32'h0);
            chk("press_e12_act",  32'(bus.active_ch), 32'h2);
         end
      end

      // 3) bounce on ch1: high for 4 cycles, then back low
      bus.noisy = 4'b0110;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("bounce_deb", 32'(bus.debounced), 32'h4);
         chk("bounce_chg", 32'(bus.changed),   32'h0);
         if (i == 3) begin
            chk("bounce_e3_busy", 32'(bus.busy),      32'h1);
            chk("bounce_e3_act",  32'(bus.active_ch), 32'h1);
         end
         if (i == 6) chk("bounce_e6_busy", 32'(bus.busy), 32'h1);
         if (i == 7) chk("bounce_e7_busy", 32'(bus.busy), 32'h0);
         if (i == 4) bus.noisy = 4'b0100;
      end

      // 4) ch0 and ch3 rise together from reset
      apply_reset(4'b0000, 2, "rst4");
      tick();
      bus.noisy = 4'b1001;
      for (int i = 1; i <= 22; i++) begin
         tick();
         chk("sim_onehot", 32'($onehot0(bus.changed)), 32'h1);
         if (i == 3) begin
            chk("sim_e3_busy", 32'(bus.busy),      32'h1);
            chk("sim_e3_act",  32'(bus.active_ch), 32'h0);
         end
         if (i == 11) begin
            chk("sim_e11_deb",  32'(bus.debounced), 32'h1);
            chk("sim_e11_chg",  32'(bus.changed),   32'h1);
            chk("sim_e11_busy", 32'(bus.busy),      32'h0);
         end
         if (i == 12) begin
            chk("sim_e12_busy", 32'(bus.busy),      32'h1);
            chk("sim_e12_act",  32'(bus.active_ch), 32'h3);
            chk("sim_e12_chg",  32'(bus.changed),   32'h0);
         end
         if (i == 19) chk("sim_e19_deb", 32'(bus.debounced), 32'h1);
         if (i == 20) begin
            chk("sim_e20_deb",  32'(bus.debounced), 32'h9);
            chk("sim_e20_chg",  32'(bus.changed),   32'h8);
            chk("sim_e20_busy", 32'(bus.busy),      32'h0);
         end
         if (i == 21) chk("sim_e21_chg", 32'(bus.changed), 32'h0);
      end

      // 5) fairness: ch0 toggles every 3 cycles, ch1 held high
      apply_reset(4'b0000, 2, "rst5");
      tick();
      bus.noisy = 4'b0011;
      for (int i = 1; i <= 40; i++) begin
         tick();
         chk("fair_deb0", 32'(bus.debounced[0]), 32'h0);
         if (i == 3) begin
            chk("fair_e3_busy", 32'(bus.busy),      32'h1);
            chk("fair_e3_act",  32'(bus.active_ch), 32'h0);
         end
         if (i == 6) chk("fair_e6_busy", 32'(bus.busy), 32'h0);
         if (i == 7) begin
            chk("fair_e7_busy", 32'(bus.busy),      32'h1);
            chk("fair_e7_act",  32'(bus.active_ch), 32'h1);
         end
         if (i == 14) chk("fair_e14_deb", 32'(bus.debounced), 32'h0);
         if (i == 15) begin
            chk("fair_e15_deb", 32'(bus.debounced), 32'h2);
            chk("fair_e15_chg", 32'(bus.changed),   32'h2);
         end
         if (i % 3 == 0) bus.noisy[0] = ~bus.noisy[0];
      end

      // 6) reset in the middle of a ch2 window (timer = 5 after e8)
      apply_reset(4'b0000, 2, "rst6");
      tick();
      bus.noisy = 4'b0100;
      repeat (8) tick();
      chk("mid_e8_busy", 32'(bus.busy),      32'h1);
      chk("mid_e8_act",  32'(bus.active_ch), 32'h2);
      apply_reset(4'b0100, 2, "mid");
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i == 2) chk("mid_e2_busy", 32'(bus.busy), 32'h0);
         if (i == 3) begin
            chk("mid_e3_busy", 32'(bus.busy),      32'h1);
            chk("mid_e3_act",  32'(bus.active_ch), 32'h2);
         end
         if (i <= 10) chk("mid_win_deb", 32'(bus.debounced), 32'h0);
         if (i == 11) begin
            chk("mid_e11_deb", 32'(bus.debounced), 32'h4);
            chk("mid_e11_chg", 32'(bus.changed),   32'h4);
         end
      end

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces NUM_CH noisy inputs (buttons, switches, UART-board jumpers) with a single shared debounce timer instead of one 19-bit counter per input.
- A round-robin scheduler grants the timer to one channel at a time. That channel's stable level is committed only after it holds its new level for a full debounce window.
- Sits between top-level pads and the user logic.

Parameters:
- NUM_CH, 4, number of noisy input channels (2..16).
- DEBOUNCE_CYCLES, 500000, number of clock cycles a new level must persist before commit (>= 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the shared timer (derived; never overridden).
- CH_W, $clog2(NUM_CH), width of the channel index (derived).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- noisy  in  NUM_CH  raw asynchronous inputs.
- debounced  out  NUM_CH  committed clean levels.
- changed  out  NUM_CH  one-cycle pulse on the bit whose debounced value just changed.
- busy  out  1  high while the timer is granted to a channel.
- active_ch  out  CH_W  index of the granted channel; holds the last grant when idle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). Every flop clears immediately on reset_n=0, independent of clk.
- Reset values: debounced=0, changed=0, busy=0, active_ch=0, sync flops=0, timer=0, state=IDLE, RR pointer=0 (ch0 has top priority).
- Synchronizer: a 2-flop synchronizer per channel produces sync[i].
- Request: req[i] = sync[i] != debounced[i], computed combinationally.
- FSM has two states, IDLE and TIMING.
- IDLE:
  - If req is non-zero, the round-robin arbiter picks the first requesting channel at or after the pointer, wrapping modulo NUM_CH.
  - At the next edge: active_ch<=grant, timer<=0, busy<=1, state<=TIMING.
  - Otherwise stay in IDLE.
- TIMING (channel c = active_ch), evaluated each cycle:
  - Abort: if sync[c]==debounced[c], the channel bounced back. Return to IDLE, busy<=0, no commit, pointer<=c+1 mod NUM_CH.
  - Commit: else if timer==DEBOUNCE_CYCLES-1, then debounced[c]<=sync[c] and changed[c]<=1 for exactly one cycle. Return to IDLE, busy<=0, pointer<=c+1 mod NUM_CH.
  - Otherwise timer<=timer+1, with no wrap inside the window.
- Latency:
  - If req[c] is first visible in an IDLE cycle t, the grant takes effect at edge t+1.
  - debounced[c] updates at edge t+1+DEBOUNCE_CYCLES, provided sync[c] held steady through the window.
  - From the raw noisy edge, add 2 cycles of synchronizer delay.
- Only one channel is timed at a time. Other channels' requests wait; no pending state is stored beyond req itself. A channel that bounces back while waiting silently drops its request.
- Back-to-back grants: IDLE always lasts at least 1 cycle between windows. changed and the next grant never coincide.
- Simultaneous requests: the lowest index at or after the pointer wins. The pointer advances past the serviced channel, so no channel waits more than NUM_CH-1 windows.
- Multiple changed bits are never high in the same cycle.
- Reset asserted mid-TIMING aborts the window without commit. All outputs return to reset values asynchronously.
- A channel whose input returns to its old level during the commit cycle is still committed. Its new mismatch raises a fresh request.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic {IDLE, TIMING} sched_state_t;
  - a localparam function computing CNT_W/CH_W from a value (clog2 with minimum 1).
- One sub-module, rr_arbiter, parameterized by NUM_CH:
  - inputs: req vector and pointer.
  - outputs: grant_valid and grant index.
  - purely combinational.
- The FSM, timer, synchronizers and pointer register stay in debounce_scheduler.

Test Plan (NUM_CH=4, DEBOUNCE_CYCLES=8):
- Reset: hold reset_n=0 for 5 cycles with noisy=4'b1111 -> debounced=0, changed=0, busy=0, active_ch=0 throughout. After release, ch0 is granted first and debounced=4'b0001 at 8 cycles after its grant.
- Clean press: noisy[2] 0->1 held steady -> busy=1 and active_ch=2 for 8 cycles. Then debounced=4'b0100 and changed=4'b0100 for exactly one cycle, busy=0.
- Bounce: noisy[1] high for 4 cycles, then low -> window aborts; debounced[1]=0 and changed=0 throughout; busy falls 1 cycle after sync[1] returns to 0.
- Simultaneous: noisy[0] and noisy[3] rise in the same cycle from reset state -> ch0 commits first. ch3 is granted 1 cycle after ch0's commit and commits 9 cycles after ch0. Each changed pulse is separate.
- Fairness: ch0 toggles every 3 cycles forever while noisy[1] is held high -> ch1 is granted right after ch0's first abort and debounced[1]=1 after 8 cycles. ch0 never commits.
- Reset mid-window: assert reset_n=0 at timer=5 on ch2 -> debounced=0 and busy=0 immediately, no changed pulse. After release with noisy[2] still high, a full new 8-cycle window occurs before commit.
